// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA constants, mode encodings, RGB332 layout, bar
//               colour table and the per-axis box bounce step.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int c_H_ACTIVE = 640;
  localparam int c_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_CHECKER = 2'd1,
    MODE_BARS    = 2'd2,
    MODE_BOX     = 2'd3
  } mode_t;

  // RGB332 byte layout: {b[1:0], g[2:0], r[2:0]}
  localparam int c_R_LSB = 0;
  localparam int c_G_LSB = 3;
  localparam int c_B_LSB = 6;
  localparam logic [7:0] c_MSB_MASK = 8'(1 << (c_R_LSB + 2))
                                    | 8'(1 << (c_G_LSB + 2))
                                    | 8'(1 << (c_B_LSB + 1));

  typedef struct packed {
    logic [9:0] pos;
    logic       up;
  } axis_t;

  function automatic logic [7:0] bar_color(input logic [2:0] idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = 8'hFF;
      3'd1:    c = 8'h3F;
      3'd2:    c = 8'hF8;
      3'd3:    c = 8'h38;
      3'd4:    c = 8'hC7;
      3'd5:    c = 8'h07;
      3'd6:    c = 8'hC0;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // One frame of motion on one axis; clamps at both walls and reverses.
  function automatic axis_t axis_step(input axis_t cur, input logic [10:0] max_pos,
                                      input logic [10:0] speed);
    axis_t      nxt;
    logic [10:0] pos_ext;
    nxt     = cur;
    pos_ext = {1'b0, cur.pos};
    if (cur.up) begin
      if (pos_ext + speed >= max_pos) begin
        nxt.pos = max_pos[9:0];
        nxt.up  = 1'b0;
      end else begin
        nxt.pos = cur.pos + speed[9:0];
      end
    end else begin
      if (pos_ext <= speed) begin
        nxt.pos = 10'd0;
        nxt.up  = 1'b1;
      end else begin
        nxt.pos = cur.pos - speed[9:0];
      end
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen_if
// Description : Pixel coordinate/strobe bundle from the timing stage and the
//               colour byte returned to the output stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_pattern_gen_if;
  logic       pix_en;
  logic [9:0] col;
  logic [9:0] row;
  logic       in_frame;
  logic       frame_start;
  logic [1:0] mode_sel;
  logic [7:0] color;

  modport master (output pix_en, col, row, in_frame, frame_start, mode_sel,
                  input  color);
  modport slave  (input  pix_en, col, row, in_frame, frame_start, mode_sel,
                  output color);
endinterface
`default_nettype wire

// File: rtl/vga_box_mover.sv
`default_nettype none
// ============================================================================
// Module      : vga_box_mover
// Description : Bouncing-box position registers, advanced once per frame_start.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = c_H_ACTIVE,
  parameter int V_ACTIVE  = c_V_ACTIVE,
  parameter int BOX_SIZE  = 32,
  parameter int BOX_SPEED = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  output logic [9:0] box_x,
  output logic [9:0] box_y
);

  localparam logic [10:0] c_X_MAX = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] c_Y_MAX = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] c_SPEED = 11'(BOX_SPEED);

  axis_t r_x;
  axis_t r_y;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= {10'd0, 1'b1};
      r_y <= {10'd0, 1'b1};
    end else if (frame_start) begin
      r_x <= axis_step(r_x, c_X_MAX, c_SPEED);
      r_y <= axis_step(r_y, c_Y_MAX, c_SPEED);
    end
  end

  assign box_x = r_x.pos;
  assign box_y = r_y.pos;

endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : Two-stage RGB332 test-pattern source (solid/checker/bars/box).
// Config      : VGA_PAT_SCANLINE_EN - dims odd rows by clearing channel MSBs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int         H_ACTIVE    = c_H_ACTIVE,
  parameter int         V_ACTIVE    = c_V_ACTIVE,
  parameter int         CHECK_LOG2  = 5,
  parameter int         BAR_WIDTH   = 80,
  parameter int         BOX_SIZE    = 32,
  parameter int         BOX_SPEED   = 2,
  parameter logic [7:0] SOLID_COLOR = 8'hFF,
  parameter logic [7:0] BOX_COLOR   = 8'h07
) (
  input  logic             clk,
  input  logic             rst,
  vga_pattern_gen_if.slave bus
);

  logic [9:0]  r_col;
  logic [9:0]  r_row;
  logic        r_in_frame;
  mode_t       r_mode;
  logic [2:0]  r_bar_idx;
  logic [10:0] r_next_edge;
  logic [7:0]  r_color;
  logic [9:0]  w_box_x;
  logic [9:0]  w_box_y;
  logic [7:0]  w_pattern;
  logic [7:0]  w_shaded;
  logic        w_in_box;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col      <= '0;
      r_row      <= '0;
      r_in_frame <= 1'b0;
      r_mode     <= MODE_SOLID;
    end else begin
      r_col      <= bus.col;
      r_row      <= bus.row;
      r_in_frame <= bus.in_frame;
      if (bus.frame_start) begin
        r_mode <= mode_t'(bus.mode_sel);
      end
    end
  end

  // Bar index tracks the next bar boundary instead of dividing col by BAR_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bar_idx   <= 3'd0;
      r_next_edge <= 11'(BAR_WIDTH);
    end else if (bus.pix_en) begin
      if (bus.col == 10'd0) begin
        r_bar_idx   <= 3'd0;
        r_next_edge <= 11'(BAR_WIDTH);
      end else if (({1'b0, bus.col} == r_next_edge) && (r_bar_idx != 3'd7)) begin
        r_bar_idx   <= r_bar_idx + 3'd1;
        r_next_edge <= r_next_edge + 11'(BAR_WIDTH);
      end
    end
  end

  vga_box_mover #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .BOX_SIZE  (BOX_SIZE),
    .BOX_SPEED (BOX_SPEED)
  ) u_box_mover (
    .clk         (clk),
    .rst         (rst),
    .frame_start (bus.frame_start),
    .box_x       (w_box_x),
    .box_y       (w_box_y)
  );

  assign w_in_box = ({1'b0, r_col} >= {1'b0, w_box_x})
                 && ({1'b0, r_col} <  {1'b0, w_box_x} + 11'(BOX_SIZE))
                 && ({1'b0, r_row} >= {1'b0, w_box_y})
                 && ({1'b0, r_row} <  {1'b0, w_box_y} + 11'(BOX_SIZE));

  always_comb begin
    w_pattern = 8'h00;
    case (r_mode)
      MODE_SOLID:   w_pattern = SOLID_COLOR;
      MODE_CHECKER: w_pattern = (r_col[CHECK_LOG2] ^ r_row[CHECK_LOG2]) ? 8'hFF : 8'h00;
      MODE_BARS:    w_pattern = bar_color(r_bar_idx);
      MODE_BOX:     w_pattern = w_in_box ? BOX_COLOR : 8'h00;
      default:      w_pattern = 8'h00;
    endcase
  end

`ifdef VGA_PAT_SCANLINE_EN
  assign w_shaded = r_row[0] ? (w_pattern & ~c_MSB_MASK) : w_pattern;
`else
  assign w_shaded = w_pattern;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_color <= 8'h00;
    end else begin
      r_color <= r_in_frame ? w_shaded : 8'h00;
    end
  end

  assign bus.color = r_color;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Self-checking bench for vga_pattern_gen against a pixel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vga_pattern_gen_if bus();

  vga_pattern_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int m_mode;
  int m_bx;
  int m_by;
  int m_dx;
  int m_dy;

  logic [7:0] bar_tab [8] = '{8'hFF, 8'h3F, 8'hF8, 8'h38, 8'hC7, 8'h07, 8'hC0, 8'h00};

  function automatic logic [7:0] model_color(input int c, input int r, input bit inf);
    logic [7:0] v;
    if (!inf) return 8'h00;
    case (m_mode)
      0:       v = 8'hFF;
      1:       v = (((c / 32) + (r / 32)) % 2 == 1) ? 8'hFF : 8'h00;
      2:       v = bar_tab[c / 80];
      default: v = (c >= m_bx && c < m_bx + 32 && r >= m_by && r < m_by + 32) ? 8'h07 : 8'h00;
    endcase
`ifdef VGA_PAT_SCANLINE_EN
    if (r % 2 == 1) v = v & 8'h5B;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
  endtask

  task automatic step_axis(inout int pos, inout int dir, input int maxp);
    int nb;
    nb = pos + dir * 2;
    if (nb >= maxp) begin
      pos = maxp; dir = -1;
    end else if (nb <= 0) begin
      pos = 0; dir = 1;
    end else begin
      pos = nb;
    end
  endtask

  task automatic pulse_frame(input int mode);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.mode_sel    = 2'(mode);
    bus.in_frame    = 1'b0;
    bus.pix_en      = 1'b0;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.mode_sel    = 2'($urandom);
    m_mode = mode;
    step_axis(m_bx, m_dx, 640 - 32);
    step_axis(m_by, m_dy, 480 - 32);
  endtask

  task automatic drive_pixel(input int c, input int r, input bit inf, output logic [7:0] got);
    @(negedge clk);
    bus.col      = 10'(c);
    bus.row      = 10'(r);
    bus.in_frame = inf;
    bus.pix_en   = 1'b1;
    bus.mode_sel = 2'($urandom);
    @(negedge clk);
    bus.pix_en = 1'b0;
    @(negedge clk);
    got = bus.color;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.col = 10'd5; bus.row = 10'd5; bus.in_frame = 1'b1;
    bus.pix_en = 1'b0; bus.frame_start = 1'b0; bus.mode_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.color !== 8'h00) begin
        failures++; $display("FAIL reset_hold got=%h exp=00", bus.color);
      end
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (bus.color !== 8'h00) begin
      failures++; $display("FAIL reset_release_1clk got=%h exp=00", bus.color);
    end
    @(negedge clk);
    checks++;
    if (bus.color !== model_color(5, 5, 1'b1)) begin
      failures++; $display("FAIL reset_release_2clk got=%h exp=%h", bus.color, model_color(5, 5, 1'b1));
    end
  endtask

  task automatic test_mode_latch();
    logic [7:0] got;
    bus.mode_sel = 2'd1;
    repeat (3) @(negedge clk);
    drive_pixel(32, 32, 1'b1, got);
    checks++;
    if (got !== 8'hFF) begin
      failures++; $display("FAIL mode_ignored got=%h exp=FF", got);
    end
    pulse_frame(1);
    drive_pixel(32, 0, 1'b1, got);
    checks++;
    if (got !== model_color(32, 0, 1'b1)) begin
      failures++; $display("FAIL checker_32_0 got=%h exp=%h", got, model_color(32, 0, 1'b1));
    end
    drive_pixel(32, 32, 1'b1, got);
    checks++;
    if (got !== model_color(32, 32, 1'b1)) begin
      failures++; $display("FAIL checker_32_32 got=%h exp=%h", got, model_color(32, 32, 1'b1));
    end
  endtask

  task automatic test_bars();
    logic [7:0] got;
    pulse_frame(2);
    for (int c = 0; c < 640; c++) begin
      drive_pixel(c, 0, 1'b1, got);
      checks++;
      if (got !== model_color(c, 0, 1'b1)) begin
        failures++; $display("FAIL bars col=%0d got=%h exp=%h", c, got, model_color(c, 0, 1'b1));
      end
    end
  endtask

  task automatic test_box();
    logic [7:0] got;
    int pc;
    int pr;
    for (int f = 0; f < 400; f++) begin
      pulse_frame(3);
      for (int p = 0; p < 3; p++) begin
        case (p)
          0:       begin pc = m_bx;      pr = m_by;      end
          1:       begin pc = m_bx + 31; pr = m_by + 31; end
          default: begin pc = (m_bx > 0) ? m_bx - 1 : m_bx + 32; pr = m_by; end
        endcase
        drive_pixel(pc, pr, 1'b1, got);
        checks++;
        if (got !== model_color(pc, pr, 1'b1)) begin
          failures++;
          $display("FAIL box frame=%0d col=%0d row=%0d got=%h exp=%h", f, pc, pr, got,
                   model_color(pc, pr, 1'b1));
        end
      end
    end
  endtask

  task automatic test_blank_and_midreset();
    logic [7:0] got;
    for (int m = 0; m < 4; m++) begin
      pulse_frame(m);
      drive_pixel($urandom_range(0, 639), $urandom_range(0, 479), 1'b0, got);
      checks++;
      if (got !== 8'h00) begin
        failures++; $display("FAIL blank mode=%0d got=%h exp=00", m, got);
      end
    end
    pulse_frame(0);
    @(negedge clk);
    bus.col = 10'd100; bus.row = 10'd100; bus.in_frame = 1'b1; bus.pix_en = 1'b1;
    @(negedge clk);
    bus.pix_en = 1'b0;
    @(negedge clk);
    bus.in_frame = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.color !== model_color(100, 100, 1'b1)) begin
      failures++; $display("FAIL blank_latency_1clk got=%h exp=%h", bus.color, model_color(100, 100, 1'b1));
    end
    @(negedge clk);
    checks++;
    if (bus.color !== 8'h00) begin
      failures++; $display("FAIL blank_latency_2clk got=%h exp=00", bus.color);
    end
    pulse_frame(3);
    drive_pixel(m_bx + 4, m_by + 4, 1'b1, got);
    checks++;
    if (got !== model_color(m_bx + 4, m_by + 4, 1'b1)) begin
      failures++; $display("FAIL prereset_box got=%h exp=%h", got, model_color(m_bx + 4, m_by + 4, 1'b1));
    end
    @(negedge clk);
    bus.col = 10'(m_bx + 4); bus.row = 10'(m_by + 4); bus.in_frame = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.color !== 8'h00) begin
      failures++; $display("FAIL midline_reset got=%h exp=00", bus.color);
    end
    rst = 1'b0;
    model_reset();
    pulse_frame(3);
    drive_pixel(2, 2, 1'b1, got);
    checks++;
    if (got !== model_color(2, 2, 1'b1)) begin
      failures++; $display("FAIL box_after_reset_in got=%h exp=%h", got, model_color(2, 2, 1'b1));
    end
    drive_pixel(1, 1, 1'b1, got);
    checks++;
    if (got !== model_color(1, 1, 1'b1)) begin
      failures++; $display("FAIL box_after_reset_out got=%h exp=%h", got, model_color(1, 1, 1'b1));
    end
  endtask

  task automatic test_scanline();
    logic [7:0] got;
    pulse_frame(0);
    for (int r = 0; r < 2; r++) begin
      drive_pixel(10, r, 1'b1, got);
      checks++;
      if (got !== model_color(10, r, 1'b1)) begin
        failures++; $display("FAIL scanline row=%0d got=%h exp=%h", r, got, model_color(10, r, 1'b1));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] got;
    int c;
    int r;
    bit inf;
    int modes [3] = '{0, 1, 3};
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) pulse_frame(modes[$urandom_range(0, 2)]);
      if ($urandom_range(0, 1) == 1) begin
        c = m_bx + $urandom_range(0, 40) - 4;
        r = m_by + $urandom_range(0, 40) - 4;
        if (c < 0) c = 0;
        if (c > 639) c = 639;
        if (r < 0) r = 0;
        if (r > 479) r = 479;
      end else begin
        c = $urandom_range(0, 639);
        r = $urandom_range(0, 479);
      end
      inf = ($urandom_range(0, 9) != 0);
      drive_pixel(c, r, inf, got);
      checks++;
      if (got !== model_color(c, r, inf)) begin
        failures++;
        $display("FAIL random mode=%0d col=%0d row=%0d inf=%0d got=%h exp=%h", m_mode, c, r, inf,
                 got, model_color(c, r, inf));
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_mode_latch();
    test_bars();
    test_box();
    test_blank_and_midreset();
    test_scanline();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
